cmd_front_end: RTL and testbench
================================

# cmd_front_end

Package-side responder for the host command interface. Accepts `command`/`valid`/`write_data` from the pattern, queues them in a DEPTH-entry FIFO, and issues them in order to the controller back-end over a valid/ready handshake. It returns back-end read data to the pattern as `read_data`/`read_data_valid` and advertises per-bank command permission on `ba_cmd_pm`.

## Interface
- `DQ_BITS`, 8, DQ width; data bus is DQ_BITS*8 bits.
- `ROW_BITS`, 14, row address width.
- `COL_BITS`, 10, column address width.
- `DEPTH`, 8, command FIFO entries (power of two, ≥2).
- `BANK_MAX`, 4, max queued commands per bank.
- `clk`  in  1  sole clock; all logic on rising edge.
- `power_on_rst_n`  in  1  synchronous, active-low reset.
- `command`  in  CMD_W=4+ROW_BITS+COL_BITS  {op[1:0], bank[1:0], row, col}; op 00 NOP, 01 READ, 10 WRITE, 11 REFRESH.
- `valid`  in  1  command present this cycle.
- `write_data`  in  DQ_BITS*8  data for WRITE, sampled with the command.
- `ba_cmd_pm`  out  4  bit b=1: command to bank b is accepted this cycle.
- `read_data`  out  DQ_BITS*8  returned read data.
- `read_data_valid`  out  1  one-cycle pulse per returned beat.
- `be_cmd_valid`  out  1  head-of-queue command valid.
- `be_cmd_ready`  in  1  back-end accepts.
- `be_cmd`  out  CMD_W  head command.
- `be_wdata`  out  DQ_BITS*8  head write data.
- `be_rdata_valid`  in  1  back-end read beat.
- `be_rdata`  in  DQ_BITS*8  back-end read data.
- `proto_err`  out  1  sticky protocol error (see Configuration).

## Operation
- Accept when `valid` is high, op≠NOP, and `ba_cmd_pm[bank]`=1. Push {command, write_data} into the FIFO. Increment `pend[bank]`.
- NOP with `valid` is ignored and not queued.
- Non-NOP to a bank whose bit is 0 is dropped. No state change except `proto_err`.
- `ba_cmd_pm[b]` = !full && `pend[b]` < BANK_MAX. It is combinational from registered state only, with no path from `valid` or `command`.
- Issue: `be_cmd_valid` = !empty. On `be_cmd_valid && be_cmd_ready`, pop and decrement `pend[head.bank]`. If op=READ, increment `rd_out`.
- Same-cycle accept and issue to the same bank leaves `pend` unchanged. FIFO count is also unchanged.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full = MSBs differ and LSBs equal.
- `be_cmd`/`be_wdata` stay stable while `be_cmd_valid && !be_cmd_ready`.
- Read return: on `be_rdata_valid`:
  - if `rd_out`>0: register the data, pulse `read_data_valid` next cycle, decrement `rd_out`.
  - if `rd_out`=0: discard.
- `rd_out` is 6 bits. The back-end guarantees ≤63 outstanding reads.
- Same-cycle READ issue and return: `rd_out` unchanged. Data is forwarded only if `rd_out`>0 before the cycle.

## Timing
- Reset (`power_on_rst_n`=0 at the edge):
  - FIFO flushed, `pend`/`rd_out` cleared.
  - `ba_cmd_pm`=0 while in reset. `be_cmd_valid`=0, `read_data_valid`=0, `read_data`=0, `proto_err`=0.
  - Mid-operation reset discards queued commands and in-flight read data.
- First cycle after release: `ba_cmd_pm`=4'hF.
- Command latency: accepted at edge N; `be_cmd_valid` high after edge N. There is no same-cycle bypass.
- Read latency: `be_rdata_valid` sampled at edge N; `read_data_valid`/`read_data` valid after edge N, for exactly one cycle.
- Back-to-back accepts are allowed every cycle while the permission bit is high.
- When the FIFO becomes full at edge N, all `ba_cmd_pm` bits are 0 after edge N. They recover the cycle after a pop.

## Configuration
- `CMD_FE_PROTO_CHK_EN` defined:
  - `proto_err` sets on a dropped non-NOP command (bank bit low).
  - `proto_err` sets on `be_rdata_valid` with `rd_out`=0.
  - It holds until reset.
- Undefined: `proto_err` is tied 0. Drop/discard behaviour is identical.

## Test plan
- Reset release, idle: `ba_cmd_pm`=4'hF; `be_cmd_valid`=0; `read_data_valid`=0.
- WRITE bank1 row 5 col 3 data 64'hA5A5… with `be_cmd_ready`=1 -> next cycle `be_cmd` matches, `be_wdata`=64'hA5A5…; after the pop, `pend[1]`=0.
- 4 commands to bank 2 with `be_cmd_ready`=0 -> `ba_cmd_pm`=4'hB after the 4th. A 5th to bank 2 is dropped, `proto_err`=1 with macro. 4 more to banks 0/1 fill the FIFO, then `ba_cmd_pm`=0.
- READ issued, then `be_rdata_valid` with 64'h1234 -> `read_data_valid` one cycle later with 64'h1234. A second unsolicited beat is discarded and sets `proto_err`.
- Simultaneous accept and pop on a full-minus-one FIFO for the same bank -> count and `pend` unchanged; 16 consecutive such cycles exercise pointer wrap with in-order data.
- Reset asserted with 5 queued commands and 2 outstanding reads -> `be_cmd_valid`=0; later `be_rdata_valid` beats are not forwarded.

Source files
------------

// File: rtl/cmd_front_end.sv
// Host command front end: in-order command FIFO with per-bank admission and read-data return.
// Define CMD_FE_PROTO_CHK_EN to enable the sticky proto_err flag; otherwise it is tied low.
module cmd_front_end #(
  parameter int DQ_BITS  = 8,
  parameter int ROW_BITS = 14,
  parameter int COL_BITS = 10,
  parameter int DEPTH    = 8,
  parameter int BANK_MAX = 4
) (
  input  logic                           clk,
  input  logic                           power_on_rst_n,
  input  logic [4+ROW_BITS+COL_BITS-1:0] command,
  input  logic                           valid,
  input  logic [DQ_BITS*8-1:0]           write_data,
  output logic [3:0]                     ba_cmd_pm,
  output logic [DQ_BITS*8-1:0]           read_data,
  output logic                           read_data_valid,
  output logic                           be_cmd_valid,
  input  logic                           be_cmd_ready,
  output logic [4+ROW_BITS+COL_BITS-1:0] be_cmd,
  output logic [DQ_BITS*8-1:0]           be_wdata,
  input  logic                           be_rdata_valid,
  input  logic [DQ_BITS*8-1:0]           be_rdata,
  output logic                           proto_err
);
  localparam int CMD_W = 4 + ROW_BITS + COL_BITS;
  localparam int DW    = DQ_BITS * 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(BANK_MAX + 1);
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;

  logic [CMD_W-1:0] r_cmd_mem [DEPTH];
  logic [DW-1:0]    r_wd_mem  [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [PW-1:0]    r_pend [4];
  logic [5:0]       r_rd_out;
  logic             r_run;
  logic [DW-1:0]    r_read_data;
  logic             r_rdv;

  logic       w_empty;
  logic       w_full;
  logic       w_acc;
  logic       w_pop;
  logic       w_rd_issue;
  logic       w_rd_ret;
  logic [1:0] w_in_op;
  logic [1:0] w_in_bank;
  logic [1:0] w_hd_op;
  logic [1:0] w_hd_bank;
  logic [3:0] w_pm;
  logic [3:0] w_inc;
  logic [3:0] w_dec;

  assign be_cmd          = r_cmd_mem[r_rd_ptr[AW-1:0]];
  assign be_wdata        = r_wd_mem[r_rd_ptr[AW-1:0]];
  assign be_cmd_valid    = !w_empty;
  assign ba_cmd_pm       = w_pm;
  assign read_data       = r_read_data;
  assign read_data_valid = r_rdv;

  // Admission, issue and per-bank bookkeeping decode; permission uses registered state only.
  always_comb begin
    w_in_op   = command[CMD_W-1 -: 2];
    w_in_bank = command[CMD_W-3 -: 2];
    w_hd_op   = be_cmd[CMD_W-1 -: 2];
    w_hd_bank = be_cmd[CMD_W-3 -: 2];
    w_empty   = (r_wr_ptr == r_rd_ptr);
    w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pm      = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      w_pm[b] = r_run && !w_full && (r_pend[b] < PW'(BANK_MAX));
    end
    w_acc      = valid && (w_in_op != OP_NOP) && w_pm[w_in_bank];
    w_pop      = !w_empty && be_cmd_ready;
    w_rd_issue = w_pop && (w_hd_op == OP_READ);
    w_rd_ret   = be_rdata_valid && (r_rd_out != 6'd0);
    w_inc = 4'b0000;
    w_dec = 4'b0000;
    if (w_acc) begin
      w_inc[w_in_bank] = 1'b1;
    end else begin
      w_inc = 4'b0000;
    end
    if (w_pop) begin
      w_dec[w_hd_bank] = 1'b1;
    end else begin
      w_dec = 4'b0000;
    end
  end

  // FIFO storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_cmd_mem[r_wr_ptr[AW-1:0]] <= command;
      r_wd_mem[r_wr_ptr[AW-1:0]]  <= write_data;
    end
  end

  // Pointers, pending counters, outstanding-read count and read return.
  always_ff @(posedge clk) begin
    if (!power_on_rst_n) begin
      r_run       <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_out    <= 6'd0;
      r_read_data <= '0;
      r_rdv       <= 1'b0;
      for (int b = 0; b < 4; b++) r_pend[b] <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_acc) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      for (int b = 0; b < 4; b++) begin
        case ({w_inc[b], w_dec[b]})
          2'b10:   r_pend[b] <= r_pend[b] + PW'(1);
          2'b01:   r_pend[b] <= r_pend[b] - PW'(1);
          default: r_pend[b] <= r_pend[b];
        endcase
      end
      case ({w_rd_issue, w_rd_ret})
        2'b10:   r_rd_out <= r_rd_out + 6'd1;
        2'b01:   r_rd_out <= r_rd_out - 6'd1;
        default: r_rd_out <= r_rd_out;
      endcase
      r_rdv <= w_rd_ret;
      if (w_rd_ret) r_read_data <= be_rdata;
    end
  end

`ifdef CMD_FE_PROTO_CHK_EN
  logic r_proto_err;
  logic w_drop;
  logic w_unsol;

  assign w_drop    = valid && (w_in_op != OP_NOP) && !w_pm[w_in_bank];
  assign w_unsol   = be_rdata_valid && (r_rd_out == 6'd0);
  assign proto_err = r_proto_err;

  // Sticky error: set on a refused command or an unsolicited read beat.
  always_ff @(posedge clk) begin
    if (!power_on_rst_n) begin
      r_proto_err <= 1'b0;
    end else if (w_drop || w_unsol) begin
      r_proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_cmd_front_end.sv
// Directed self-checking bench for cmd_front_end (default parameters, 64-bit data, 28-bit command).
module tb_cmd_front_end;
  localparam int CW = 28;
  localparam int DW = 64;
`ifdef CMD_FE_PROTO_CHK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] command;
  logic          valid;
  logic [DW-1:0] wdata;
  logic [3:0]    pm;
  logic [DW-1:0] rdata;
  logic          rdv;
  logic          bev;
  logic          ber;
  logic [CW-1:0] bec;
  logic [DW-1:0] bewd;
  logic          berv;
  logic [DW-1:0] berd;
  logic          perr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW-1:0] qc[$];
  logic [DW-1:0] qd[$];
  logic [CW-1:0] exp_c [8];
  logic [DW-1:0] exp_d [8];
  logic [CW-1:0] hc;
  logic [CW-1:0] nc;

  always #5 clk = ~clk;

  cmd_front_end dut (
    .clk(clk), .power_on_rst_n(rst_n), .command(command), .valid(valid),
    .write_data(wdata), .ba_cmd_pm(pm), .read_data(rdata), .read_data_valid(rdv),
    .be_cmd_valid(bev), .be_cmd_ready(ber), .be_cmd(bec), .be_wdata(bewd),
    .be_rdata_valid(berv), .be_rdata(berd), .proto_err(perr)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] mk(input logic [1:0] op, input logic [1:0] bank,
                                       input int row, input int col);
    logic [13:0] r;
    logic [9:0]  c;
    r = row[13:0];
    c = col[9:0];
    return {op, bank, r, c};
  endfunction

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    command = c;
    wdata   = d;
    valid   = 1'b1;
    tick();
    valid   = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; command = '0; valid = 1'b0; wdata = '0;
    ber = 1'b0; berv = 1'b0; berd = '0;
    repeat (3) tick();
    chk("rst_pm", pm, 4'h0);
    chk("rst_bev", bev, 1'b0);
    chk("rst_rdv", rdv, 1'b0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_perr", perr, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("idle_pm", pm, 4'hF);
    chk("idle_bev", bev, 1'b0);
    chk("idle_rdv", rdv, 1'b0);

    // Single WRITE with the back-end ready
    ber = 1'b1;
    push(mk(WR, 2'd1, 5, 3), 64'hA5A5A5A5A5A5A5A5);
    chk("wr_bev", bev, 1'b1);
    chk("wr_cmd", bec, mk(WR, 2'd1, 5, 3));
    chk("wr_data", bewd, 64'hA5A5A5A5A5A5A5A5);
    tick();
    chk("wr_popped_bev", bev, 1'b0);
    chk("wr_popped_pm", pm, 4'hF);

    // Bank limit, drop and FIFO full with the back-end stalled
    ber = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_c[i] = mk(WR, 2'd2, i + 1, i);
      exp_d[i] = 64'h1000 + 64'(i);
      push(exp_c[i], exp_d[i]);
    end
    chk("bank2_limit_pm", pm, 4'hB);
    push(mk(WR, 2'd2, 5, 5), 64'hBAD);
    chk("drop_pm", pm, 4'hB);
    chk("drop_perr", perr, PCHK);
    for (int i = 4; i < 8; i++) begin
      exp_c[i] = mk(WR, 2'(i % 2), i + 6, i);
      exp_d[i] = 64'h2000 + 64'(i);
      push(exp_c[i], exp_d[i]);
      if (i == 6) chk("fill7_pm", pm, 4'hB);
    end
    chk("full_pm", pm, 4'h0);
    chk("stall_cmd", bec, exp_c[0]);
    chk("stall_data", bewd, exp_d[0]);

    // Drain in order; permission recovers after the first pop
    ber = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_bev", bev, 1'b1);
      chk("drain_cmd", bec, exp_c[i]);
      chk("drain_data", bewd, exp_d[i]);
      tick();
      if (i == 0) chk("recover_pm", pm, 4'hF);
    end
    chk("drained_bev", bev, 1'b0);

    // Read return and unsolicited beat
    do_reset();
    chk("rst2_perr", perr, 1'b0);
    push(mk(RD, 2'd3, 7, 9), 64'h0);
    chk("rd_bev", bev, 1'b1);
    tick();
    chk("rd_issued_bev", bev, 1'b0);
    chk("rd_early_rdv", rdv, 1'b0);
    berv = 1'b1;
    berd = 64'h1234;
    tick();
    berv = 1'b0;
    chk("rd_rdv", rdv, 1'b1);
    chk("rd_data", rdata, 64'h1234);
    tick();
    chk("rd_pulse_end", rdv, 1'b0);
    berv = 1'b1;
    berd = 64'hDEAD;
    tick();
    berv = 1'b0;
    chk("unsol_rdv", rdv, 1'b0);
    chk("unsol_data", rdata, 64'h1234);
    chk("unsol_perr", perr, PCHK);

    // Full-minus-one with same-bank accept and pop for 16 cycles
    ber = 1'b0;
    for (int i = 0; i < 7; i++) begin
      nc = mk(WR, 2'(i % 4), i, i);
      qc.push_back(nc);
      qd.push_back(64'h200 + 64'(i));
      push(nc, 64'h200 + 64'(i));
    end
    chk("fm1_pm", pm, 4'hF);
    ber   = 1'b1;
    valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("wrap_bev", bev, 1'b1);
      chk("wrap_cmd", bec, qc[0]);
      chk("wrap_data", bewd, qd[0]);
      chk("wrap_pm", pm, 4'hF);
      hc = qc[0];
      nc = mk(WR, hc[25:24], 100 + i, i);
      command = nc;
      wdata   = 64'h300 + 64'(i);
      tick();
      void'(qc.pop_front());
      void'(qd.pop_front());
      qc.push_back(nc);
      qd.push_back(64'h300 + 64'(i));
    end
    valid = 1'b0;
    ber   = 1'b0;
    tick();
    chk("wrap_cnt_pm", pm, 4'hF);
    chk("wrap_head", bec, qc[0]);
    push(mk(WR, 2'd3, 50, 50), 64'h400);
    chk("wrap_full_pm", pm, 4'h0);

    // Mid-operation reset with queued commands and outstanding reads
    do_reset();
    push(mk(RD, 2'd0, 1, 1), 64'h0);
    push(mk(RD, 2'd1, 2, 2), 64'h0);
    ber = 1'b1;
    tick();
    tick();
    ber = 1'b0;
    chk("rds_out_bev", bev, 1'b0);
    for (int i = 0; i < 5; i++) push(mk(WR, 2'(i % 4), i, i), 64'h500 + 64'(i));
    chk("q5_bev", bev, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("midrst_bev", bev, 1'b0);
    chk("midrst_pm", pm, 4'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_pm", pm, 4'hF);
    chk("post_rst_bev", bev, 1'b0);
    chk("post_rst_rdata", rdata, 64'h0);
    berv = 1'b1;
    berd = 64'h77;
    tick();
    berv = 1'b0;
    chk("stale_rdv", rdv, 1'b0);
    tick();
    chk("stale_rdv2", rdv, 1'b0);
    chk("stale_perr", perr, PCHK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
